// File: rtl/mem_arb_pkg.sv
// Shared types and sizing for the memory arbiter: state encoding, default
// burst/timeout limits and counter widths.
package mem_arb_pkg;

    localparam int DEF_MAX_DM_BURST = 4;
    localparam int DEF_TIMEOUT      = 255;
    localparam int TMR_W            = 8;

    // Burst counter must hold the value MAX_DM_BURST itself.
    function automatic int burst_width(input int max_burst);
        return (max_burst < 1) ? 1 : $clog2(max_burst + 1);
    endfunction

    localparam int BURST_W = burst_width(DEF_MAX_DM_BURST);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GNT_IF = 2'd1,
        GNT_DM = 2'd2,
        RESP   = 2'd3
    } arb_state_e;

endpackage

// File: rtl/bus_timer.sv
// Bus acknowledge watchdog: down-counter reloaded while idle, flags expiry on
// the TIMEOUT-th enabled cycle.
module bus_timer
    import mem_arb_pkg::*;
#(
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    // Loaded with TIMEOUT-1 so the terminal count of zero lands on the
    // TIMEOUT-th bus cycle after the grant edge.
    localparam logic [TMR_W-1:0] TC_LOAD = TMR_W'(TIMEOUT - 1);

    logic [TMR_W-1:0] cnt;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= TC_LOAD;
        end else if (enable && (cnt != '0)) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign expired = enable && (cnt == '0);

endmodule

// File: rtl/mem_arbiter.sv
// Two-master (fetch / data) arbiter onto a single registered memory bus, with
// bounded data bursts and an acknowledge timeout.
//
// state  | meaning
// IDLE   | sample requesters, register winner onto bus
// GNT_IF | fetch transaction on bus, waiting for ack or timeout
// GNT_DM | data transaction on bus, waiting for ack or timeout
// RESP   | ack cycle to requester; requests ignored
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int MAX_DM_BURST = DEF_MAX_DM_BURST,
    parameter int TIMEOUT      = DEF_TIMEOUT
) (
    input  logic        i_clk,
    input  logic        i_rst,

    input  logic        i_if_req,
    input  logic [31:0] i_if_addr,
    output logic        o_if_ack,
    output logic        o_if_err,
    output logic [31:0] o_if_rdata,

    input  logic        i_dm_req,
    input  logic [31:0] i_dm_addr,
    input  logic [31:0] i_dm_wdata,
    input  logic        i_dm_write,
    input  logic        i_dm_rdu,
    input  logic        i_dm_byte,
    input  logic        i_dm_hwrd,
    output logic        o_dm_ack,
    output logic        o_dm_err,
    output logic [31:0] o_dm_rdata,

    output logic        o_bus_req,
    output logic        o_bus_write,
    output logic        o_bus_rdu,
    output logic        o_bus_byte,
    output logic        o_bus_hwrd,
    output logic [31:0] o_bus_addr,
    output logic [31:0] o_bus_wdata,
    input  logic        i_bus_ack,
    input  logic [31:0] i_bus_rdata
);

    localparam int BW = burst_width(MAX_DM_BURST);
    localparam logic [BW-1:0] BURST_MAX = BW'(MAX_DM_BURST);

    arb_state_e    state, state_d;
    logic [BW-1:0] burst, burst_d;

    logic        bus_req_d, bus_write_d, bus_rdu_d, bus_byte_d, bus_hwrd_d;
    logic [31:0] bus_addr_d, bus_wdata_d;
    logic        if_ack_d, if_err_d, dm_ack_d, dm_err_d;
    logic [31:0] if_rdata_d, dm_rdata_d;

    logic in_grant;
    logic expired;
    logic ack_valid;
    logic dm_wins;

    assign in_grant  = (state == GNT_IF) || (state == GNT_DM);
    assign ack_valid = i_bus_ack && o_bus_req;
    assign dm_wins   = i_dm_req && !(i_if_req && (burst == BURST_MAX));

    bus_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_bus_timer (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .clear   (!in_grant),
        .enable  (in_grant),
        .expired (expired)
    );

    always_comb begin
        state_d     = state;
        burst_d     = burst;
        bus_req_d   = o_bus_req;
        bus_write_d = o_bus_write;
        bus_rdu_d   = o_bus_rdu;
        bus_byte_d  = o_bus_byte;
        bus_hwrd_d  = o_bus_hwrd;
        bus_addr_d  = o_bus_addr;
        bus_wdata_d = o_bus_wdata;
        if_ack_d    = 1'b0;
        if_err_d    = 1'b0;
        dm_ack_d    = 1'b0;
        dm_err_d    = 1'b0;
        if_rdata_d  = o_if_rdata;
        dm_rdata_d  = o_dm_rdata;

        case (state)
            IDLE: begin
                if (dm_wins) begin
                    state_d     = GNT_DM;
                    bus_req_d   = 1'b1;
                    bus_addr_d  = i_dm_addr;
                    bus_wdata_d = i_dm_wdata;
                    bus_write_d = i_dm_write;
                    bus_rdu_d   = i_dm_rdu;
                    bus_byte_d  = i_dm_byte;
                    bus_hwrd_d  = i_dm_hwrd;
                    // Only grants made while fetch is waiting count toward the burst.
                    burst_d     = i_if_req ? burst + 1'b1 : '0;
                end else if (i_if_req) begin
                    state_d     = GNT_IF;
                    bus_req_d   = 1'b1;
                    bus_addr_d  = i_if_addr;
                    bus_wdata_d = '0;
                    bus_write_d = 1'b0;
                    bus_rdu_d   = 1'b0;
                    bus_byte_d  = 1'b0;
                    bus_hwrd_d  = 1'b0;
                    burst_d     = '0;
                end
            end
            GNT_IF: begin
                if (ack_valid) begin
                    state_d    = RESP;
                    bus_req_d  = 1'b0;
                    if_ack_d   = 1'b1;
                    if_rdata_d = i_bus_rdata;
                end else if (expired) begin
                    state_d    = RESP;
                    bus_req_d  = 1'b0;
                    if_ack_d   = 1'b1;
                    if_err_d   = 1'b1;
                    if_rdata_d = '0;
                end
            end
            GNT_DM: begin
                if (ack_valid) begin
                    state_d    = RESP;
                    bus_req_d  = 1'b0;
                    dm_ack_d   = 1'b1;
                    dm_rdata_d = o_bus_write ? 32'h0 : i_bus_rdata;
                end else if (expired) begin
                    state_d    = RESP;
                    bus_req_d  = 1'b0;
                    dm_ack_d   = 1'b1;
                    dm_err_d   = 1'b1;
                    dm_rdata_d = '0;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            burst       <= '0;
            o_bus_req   <= 1'b0;
            o_bus_write <= 1'b0;
            o_bus_rdu   <= 1'b0;
            o_bus_byte  <= 1'b0;
            o_bus_hwrd  <= 1'b0;
            o_bus_addr  <= '0;
            o_bus_wdata <= '0;
            o_if_ack    <= 1'b0;
            o_if_err    <= 1'b0;
            o_if_rdata  <= '0;
            o_dm_ack    <= 1'b0;
            o_dm_err    <= 1'b0;
            o_dm_rdata  <= '0;
        end else begin
            burst       <= burst_d;
            o_bus_req   <= bus_req_d;
            o_bus_write <= bus_write_d;
            o_bus_rdu   <= bus_rdu_d;
            o_bus_byte  <= bus_byte_d;
            o_bus_hwrd  <= bus_hwrd_d;
            o_bus_addr  <= bus_addr_d;
            o_bus_wdata <= bus_wdata_d;
            o_if_ack    <= if_ack_d;
            o_if_err    <= if_err_d;
            o_if_rdata  <= if_rdata_d;
            o_dm_ack    <= dm_ack_d;
            o_dm_err    <= dm_err_d;
            o_dm_rdata  <= dm_rdata_d;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: fetch, priority, burst limit, writes,
// timeout, ack/timeout collision and reset mid-grant.
module tb_mem_arbiter;

    logic        i_clk = 1'b0;
    logic        i_rst;
    logic        i_if_req;
    logic [31:0] i_if_addr;
    logic        o_if_ack, o_if_err;
    logic [31:0] o_if_rdata;
    logic        i_dm_req;
    logic [31:0] i_dm_addr, i_dm_wdata;
    logic        i_dm_write, i_dm_rdu, i_dm_byte, i_dm_hwrd;
    logic        o_dm_ack, o_dm_err;
    logic [31:0] o_dm_rdata;
    logic        o_bus_req, o_bus_write, o_bus_rdu, o_bus_byte, o_bus_hwrd;
    logic [31:0] o_bus_addr, o_bus_wdata;
    logic        i_bus_ack;
    logic [31:0] i_bus_rdata;

    int errors = 0;
    int checks = 0;

    always #5 i_clk = ~i_clk;

    mem_arbiter dut (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_if_req    (i_if_req),
        .i_if_addr   (i_if_addr),
        .o_if_ack    (o_if_ack),
        .o_if_err    (o_if_err),
        .o_if_rdata  (o_if_rdata),
        .i_dm_req    (i_dm_req),
        .i_dm_addr   (i_dm_addr),
        .i_dm_wdata  (i_dm_wdata),
        .i_dm_write  (i_dm_write),
        .i_dm_rdu    (i_dm_rdu),
        .i_dm_byte   (i_dm_byte),
        .i_dm_hwrd   (i_dm_hwrd),
        .o_dm_ack    (o_dm_ack),
        .o_dm_err    (o_dm_err),
        .o_dm_rdata  (o_dm_rdata),
        .o_bus_req   (o_bus_req),
        .o_bus_write (o_bus_write),
        .o_bus_rdu   (o_bus_rdu),
        .o_bus_byte  (o_bus_byte),
        .o_bus_hwrd  (o_bus_hwrd),
        .o_bus_addr  (o_bus_addr),
        .o_bus_wdata (o_bus_wdata),
        .i_bus_ack   (i_bus_ack),
        .i_bus_rdata (i_bus_rdata)
    );

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        logic exp_dm;
        logic early;

        i_rst = 1'b1;
        i_if_req = 1'b1; i_if_addr = 32'h0000_0100;
        i_dm_req = 1'b0; i_dm_addr = '0; i_dm_wdata = '0;
        i_dm_write = 1'b0; i_dm_rdu = 1'b0; i_dm_byte = 1'b0; i_dm_hwrd = 1'b0;
        i_bus_ack = 1'b0; i_bus_rdata = '0;

        // Reset state, with a fetch already pending
        #3;
        chk("rst_bus_req", {31'b0, o_bus_req}, 32'd0);
        chk("rst_if_ack", {31'b0, o_if_ack}, 32'd0);
        chk("rst_dm_ack", {31'b0, o_dm_ack}, 32'd0);
        chk("rst_bus_addr", o_bus_addr, 32'd0);
        chk("rst_if_rdata", o_if_rdata, 32'd0);
        chk("rst_dm_rdata", o_dm_rdata, 32'd0);
        tick(); tick();
        i_rst = 1'b0;
        #2;
        chk("no_grant_before_edge", {31'b0, o_bus_req}, 32'd0);

        // Single fetch, slave acks in the first bus cycle
        tick();
        chk("if_bus_req", {31'b0, o_bus_req}, 32'd1);
        chk("if_bus_addr", o_bus_addr, 32'h0000_0100);
        chk("if_bus_write", {31'b0, o_bus_write}, 32'd0);
        i_bus_ack = 1'b1; i_bus_rdata = 32'h0000_0013;
        tick();
        chk("if_ack", {31'b0, o_if_ack}, 32'd1);
        chk("if_rdata", o_if_rdata, 32'h0000_0013);
        chk("if_err", {31'b0, o_if_err}, 32'd0);
        chk("if_dm_ack_quiet", {31'b0, o_dm_ack}, 32'd0);
        chk("if_bus_req_drop", {31'b0, o_bus_req}, 32'd0);
        i_bus_ack = 1'b0;
        tick();
        chk("if_ack_pulse", {31'b0, o_if_ack}, 32'd0);
        chk("resp_no_reissue", {31'b0, o_bus_req}, 32'd0);
        i_if_req = 1'b0;
        tick();
        chk("idle_no_req", {31'b0, o_bus_req}, 32'd0);

        // Simultaneous requests: DM read first, IF in the next IDLE
        i_if_req = 1'b1; i_if_addr = 32'h0000_0104;
        i_dm_req = 1'b1; i_dm_addr = 32'h0000_2000;
        tick();
        chk("sim_dm_addr", o_bus_addr, 32'h0000_2000);
        chk("sim_dm_write", {31'b0, o_bus_write}, 32'd0);
        i_bus_ack = 1'b1; i_bus_rdata = 32'hCAFE_0001;
        tick();
        chk("sim_dm_ack", {31'b0, o_dm_ack}, 32'd1);
        chk("sim_if_ack_quiet", {31'b0, o_if_ack}, 32'd0);
        chk("sim_dm_rdata", o_dm_rdata, 32'hCAFE_0001);
        i_bus_ack = 1'b0; i_dm_req = 1'b0;
        tick();
        tick();
        chk("sim_if_req", {31'b0, o_bus_req}, 32'd1);
        chk("sim_if_addr", o_bus_addr, 32'h0000_0104);
        i_bus_ack = 1'b1; i_bus_rdata = 32'h0000_0055;
        tick();
        chk("sim_if_ack", {31'b0, o_if_ack}, 32'd1);
        chk("sim_if_rdata", o_if_rdata, 32'h0000_0055);
        i_bus_ack = 1'b0; i_if_req = 1'b0;
        tick();

        // Starvation guard: DM,DM,DM,DM,IF,DM,DM
        i_if_req = 1'b1; i_if_addr = 32'h0000_0108;
        i_dm_req = 1'b1; i_dm_addr = 32'h0000_2400;
        for (int i = 0; i < 7; i++) begin
            exp_dm = (i != 4);
            tick();
            chk($sformatf("starve_req_%0d", i), {31'b0, o_bus_req}, 32'd1);
            chk($sformatf("starve_addr_%0d", i), o_bus_addr,
                exp_dm ? 32'h0000_2400 : 32'h0000_0108);
            i_bus_ack = 1'b1; i_bus_rdata = 32'h0000_0100 + 32'(i);
            tick();
            chk($sformatf("starve_dm_ack_%0d", i), {31'b0, o_dm_ack}, {31'b0, exp_dm});
            chk($sformatf("starve_if_ack_%0d", i), {31'b0, o_if_ack}, {31'b0, !exp_dm});
            i_bus_ack = 1'b0;
            if (!exp_dm) i_if_req = 1'b0;
            if (i == 6) i_dm_req = 1'b0;
            tick();
        end

        // DM byte write: controls on the bus, rdata forced to zero
        i_dm_req = 1'b1; i_dm_addr = 32'h0000_2800; i_dm_wdata = 32'hDEAD_BEEF;
        i_dm_write = 1'b1; i_dm_byte = 1'b1;
        tick();
        chk("wr_bus_write", {31'b0, o_bus_write}, 32'd1);
        chk("wr_bus_byte", {31'b0, o_bus_byte}, 32'd1);
        chk("wr_bus_wdata", o_bus_wdata, 32'hDEAD_BEEF);
        i_bus_ack = 1'b1; i_bus_rdata = 32'h0000_1234;
        tick();
        chk("wr_dm_ack", {31'b0, o_dm_ack}, 32'd1);
        chk("wr_dm_rdata", o_dm_rdata, 32'd0);
        i_dm_req = 1'b0; i_dm_byte = 1'b0;
        tick();

        // Bus ack with no bus request outstanding is ignored
        tick(); tick();
        chk("stray_ack_if", {31'b0, o_if_ack}, 32'd0);
        chk("stray_ack_dm", {31'b0, o_dm_ack}, 32'd0);
        i_bus_ack = 1'b0;

        // Timeout on a DM write that is never acknowledged
        i_dm_req = 1'b1; i_dm_addr = 32'h0000_3000; i_dm_write = 1'b1;
        tick();
        chk("to_bus_req", {31'b0, o_bus_req}, 32'd1);
        early = 1'b0;
        for (int i = 1; i < 255; i++) begin
            tick();
            if (o_dm_ack !== 1'b0 || o_bus_req !== 1'b1) early = 1'b1;
        end
        chk("to_no_early_ack", {31'b0, early}, 32'd0);
        tick();
        chk("to_dm_ack", {31'b0, o_dm_ack}, 32'd1);
        chk("to_dm_err", {31'b0, o_dm_err}, 32'd1);
        chk("to_dm_rdata", o_dm_rdata, 32'd0);
        chk("to_bus_req_drop", {31'b0, o_bus_req}, 32'd0);
        i_dm_req = 1'b0; i_dm_write = 1'b0;
        tick();
        chk("to_err_pulse", {31'b0, o_dm_err}, 32'd0);

        // Ack on the timeout edge wins
        i_dm_req = 1'b1; i_dm_addr = 32'h0000_3004;
        tick();
        for (int i = 1; i < 255; i++) tick();
        i_bus_ack = 1'b1; i_bus_rdata = 32'h0000_0077;
        tick();
        chk("ackto_dm_ack", {31'b0, o_dm_ack}, 32'd1);
        chk("ackto_dm_err", {31'b0, o_dm_err}, 32'd0);
        chk("ackto_dm_rdata", o_dm_rdata, 32'h0000_0077);
        i_bus_ack = 1'b0; i_dm_req = 1'b0;
        tick();

        // Reset pulsed during GNT_IF, held request re-granted afterwards
        i_if_req = 1'b1; i_if_addr = 32'h0000_010C;
        tick();
        chk("rg_bus_req", {31'b0, o_bus_req}, 32'd1);
        #2 i_rst = 1'b1;
        #1;
        chk("rg_async_bus_req", {31'b0, o_bus_req}, 32'd0);
        chk("rg_if_rdata_clr", o_if_rdata, 32'd0);
        chk("rg_dm_rdata_clr", o_dm_rdata, 32'd0);
        tick();
        chk("rg_no_if_ack", {31'b0, o_if_ack}, 32'd0);
        chk("rg_no_if_err", {31'b0, o_if_err}, 32'd0);
        i_rst = 1'b0;
        tick();
        chk("rg_regrant_req", {31'b0, o_bus_req}, 32'd1);
        chk("rg_regrant_addr", o_bus_addr, 32'h0000_010C);
        i_bus_ack = 1'b1; i_bus_rdata = 32'h0000_0099;
        tick();
        chk("rg_if_ack", {31'b0, o_if_ack}, 32'd1);
        chk("rg_if_rdata", o_if_rdata, 32'h0000_0099);
        i_bus_ack = 1'b0; i_if_req = 1'b0;
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter MAX_DM_BURST, default 4: consecutive data grants allowed while a fetch is pending.
REQ-002 SHALL have parameter TIMEOUT, default 255: bus cycles to wait for i_bus_ack before aborting (8-bit counter).
REQ-003 SHALL have one clock and one reset: i_clk is the single clock; i_rst is asynchronous and active-high.
REQ-004 SHALL have ports i_clk (in, 1, clock) and i_rst (in, 1, async active-high reset).
REQ-005 SHALL have fetch ports: i_if_req (in, 1), i_if_addr (in, 32), o_if_ack (out, 1), o_if_err (out, 1), o_if_rdata (out, 32).
REQ-006 SHALL have data ports: i_dm_req (in, 1), i_dm_addr (in, 32), i_dm_wdata (in, 32), i_dm_write, i_dm_rdu, i_dm_byte, i_dm_hwrd (in, 1 each), o_dm_ack (out, 1), o_dm_err (out, 1), o_dm_rdata (out, 32).
REQ-007 SHALL have bus ports: o_bus_req, o_bus_write, o_bus_rdu, o_bus_byte, o_bus_hwrd (out, 1 each); o_bus_addr, o_bus_wdata (out, 32); i_bus_ack (in, 1); i_bus_rdata (in, 32).

Function
REQ-008 SHALL implement FSM states IDLE, GNT_IF, GNT_DM, RESP.
REQ-009 SHALL, in IDLE with any request high, register the winner's address and controls onto the bus outputs, assert o_bus_req and enter GNT_IF or GNT_DM on the same edge.
REQ-010 SHALL drive all bus outputs from flops, so they are stable while o_bus_req is high.
REQ-011 SHALL give i_dm_req priority over i_if_req, except that after MAX_DM_BURST consecutive DM grants with i_if_req high, the next grant goes to fetch.
REQ-012 SHALL clear the burst counter on every IF grant and whenever i_if_req is low at a DM grant.
REQ-013 SHALL, in GNT_x, on the edge where i_bus_ack=1: drop o_bus_req, capture i_bus_rdata into o_x_rdata, pulse o_x_ack for exactly one cycle, and enter RESP.
REQ-014 SHALL drive o_dm_rdata to 0 when the acknowledged DM transaction is a write.
REQ-015 SHALL ignore all requests in RESP, then return to IDLE after one cycle, so a request held high during its ack cycle is never re-issued.
REQ-016 SHALL give minimum latency from request sampled at edge N to o_x_ack high as 2 cycles (bus acks in the first o_bus_req cycle), with one transaction every 3 cycles at best.
REQ-017 SHALL count cycles in GNT_x; when the count reaches TIMEOUT without i_bus_ack, it SHALL drop o_bus_req, pulse o_x_ack and o_x_err together, leave o_x_rdata at 0, and enter RESP.
REQ-018 SHALL give i_bus_ack precedence over timeout when both occur on the same edge.
REQ-019 SHALL ignore i_bus_ack when o_bus_req is low.
REQ-020 SHALL not sample requesters while in GNT_x; requesters hold req and fields stable until their ack.
REQ-021 SHALL never assert o_if_ack and o_dm_ack together, nor either one without a preceding grant.

Reset
REQ-022 SHALL, on i_rst assertion, immediately force state IDLE; clear the burst and timeout counters; set all outputs, including rdata, to 0.
REQ-023 SHALL, on reset mid-transaction, abandon the transaction with no ack and no err; the requester reissues it.
REQ-024 SHALL not grant earlier than the first i_clk rising edge after i_rst deasserts.

Structure
REQ-025 SHALL put the state enum, the default MAX_DM_BURST and TIMEOUT values, and the counter widths in shared package mem_arb_pkg.
REQ-026 SHALL implement the timeout counter as sub-module bus_timer (inputs: clear, enable; output: expired); all other logic stays in mem_arbiter.

Verification
REQ-027 SHALL cover a single fetch: i_if_req=1, i_if_addr=0x100, slave acks in the first cycle with rdata=0x00000013 -> o_if_ack high 2 cycles after sampling, o_if_rdata=0x00000013, o_if_err=0.
REQ-028 SHALL cover simultaneous requests: IF and DM both high, DM is a read of 0x2000 -> DM granted first, IF granted in the IDLE following DM's RESP.
REQ-029 SHALL cover starvation: DM held high for 6 transactions while IF is high -> grant order DM,DM,DM,DM,IF,DM,DM.
REQ-030 SHALL cover timeout: the bus never acks a DM write to 0x3000 -> o_dm_ack=o_dm_err=1 exactly 255 cycles after o_bus_req rose, o_dm_rdata=0.
REQ-031 SHALL cover ack and timeout together: i_bus_ack arrives on the timeout edge -> normal ack, o_dm_err=0.
REQ-032 SHALL cover reset mid-grant: i_rst pulsed in GNT_IF -> o_bus_req=0 asynchronously, no o_if_ack, and after release the held IF request is re-granted.
